// File: rtl/mem_bus_controller_if.sv
// Upstream request/response handshake for mem_bus_controller.
// The requester uses the master modport; the controller uses the slave modport.
interface mem_bus_controller_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              req;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output req, req_wr, req_addr, req_data,
        input  busy, done, rd_data
    );

    modport slave (
        input  req, req_wr, req_addr, req_data,
        output busy, done, rd_data
    );
endinterface

// File: rtl/mem_bus_controller.sv
// Synchronous master for an asynchronous SRAM-style port (wr=1 read/idle, wr=0 write).
// Single read/write requests are timed out with fixed wait counts; read data returns with a one-cycle done pulse.
module mem_bus_controller #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 4,
    parameter int WR_WAIT = 8,
    parameter int RD_WAIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_controller_if.slave up,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] databus
);
    localparam int MAX_WAIT = (WR_WAIT > RD_WAIT) ? WR_WAIT : RD_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {IDLE, SETUP, WRITE, HOLD, READ} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              wr_d;
    logic              drive_en;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              is_wr, is_wr_d;
    logic              busy_d, done_d;
    logic [DATA_W-1:0] rd_data_d;

    // The bus enable is registered alongside wr, so the controller releases
    // the bus on exactly the edge that raises wr.
    assign databus = drive_en ? data_q : {DATA_W{1'bz}};

    // NOTE: every signal is given its hold/idle value before the case so no
    // path through this block leaves a variable unassigned (which would infer a latch).
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        wr_d      = 1'b1;
        addr_d    = addr;
        data_d    = data_q;
        is_wr_d   = is_wr;
        busy_d    = up.busy;
        done_d    = 1'b0;
        rd_data_d = up.rd_data;
        case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (up.req) begin
                    addr_d  = up.req_addr;
                    data_d  = up.req_data;
                    is_wr_d = up.req_wr;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (is_wr) begin
                    state_d = WRITE;
                    wr_d    = 1'b0;
                    cnt_d   = CNT_W'(WR_WAIT - 1);
                end else begin
                    state_d = READ;
                    cnt_d   = CNT_W'(RD_WAIT - 1);
                end
            end
            WRITE: begin
                if (cnt == '0) begin
                    state_d = HOLD;
                end else begin
                    wr_d  = 1'b0;
                    cnt_d = cnt - 1'b1;
                end
            end
            HOLD: begin
                state_d = IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            READ: begin
                // Capture on the edge that ends the last wait cycle.
                if (cnt == '0) begin
                    rd_data_d = databus;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            wr         <= 1'b1;
            drive_en   <= 1'b0;
            addr       <= '0;
            data_q     <= '0;
            is_wr      <= 1'b0;
            up.busy    <= 1'b0;
            up.done    <= 1'b0;
            up.rd_data <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            wr         <= wr_d;
            drive_en   <= !wr_d;
            addr       <= addr_d;
            data_q     <= data_d;
            is_wr      <= is_wr_d;
            up.busy    <= busy_d;
            up.done    <= done_d;
            up.rd_data <= rd_data_d;
        end
    end
endmodule

// File: tb/tb_mem_bus_controller.sv
// Directed bench for mem_bus_controller with a behavioural 16x4 asynchronous memory on the bus.
// The memory returns inverted data until address/wr have been stable for 150 time units.
module tb_mem_bus_controller;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 4;
    localparam int WR_WAIT = 8;
    localparam int RD_WAIT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    wire  [DATA_W-1:0] databus;

    int vectors     = 0;
    int miscompares = 0;

    mem_bus_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_bus_controller #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_WAIT(WR_WAIT), .RD_WAIT(RD_WAIT)
    ) dut (
        .clk(clk), .reset(reset), .up(bus), .wr(wr), .addr(addr), .databus(databus)
    );

    always #5 clk = ~clk;

    // Memory model: drives only while wr=1; commits a write when wr rises after >= 80 units low.
    logic [DATA_W-1:0] mem [16];
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              last_wr;
    realtime           t_chg = 0.0;
    int                lo_cnt = 0;

    assign databus = (wr === 1'b1) ? mem_q : {DATA_W{1'bz}};

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            lo_cnt = 0;
        end else if (wr === 1'b0) begin
            lo_cnt++;
            w_data = databus;
            w_addr = addr;
        end else begin
            if (lo_cnt * 10 >= 80) mem[w_addr] = w_data;
            lo_cnt = 0;
        end
    end

    always @(negedge clk or addr or wr) begin
        if (addr !== last_addr || wr !== last_wr) begin
            t_chg     = $realtime;
            last_addr = addr;
            last_wr   = wr;
        end
        mem_q = (wr === 1'b1 && ($realtime - t_chg) >= 150.0) ? mem[addr] : ~mem[addr];
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (wr !== 1'b1) begin miscompares++; $display("FAIL reset/wr: got %b expected 1", wr); end
        vectors++;
        if (addr !== 4'h0) begin miscompares++; $display("FAIL reset/addr: got %h expected 0", addr); end
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset/busy: got %b expected 0", bus.busy); end
        vectors++;
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset/done: got %b expected 0", bus.done); end
        vectors++;
        if (bus.rd_data !== 4'h0) begin miscompares++; $display("FAIL reset/rd_data: got %h expected 0", bus.rd_data); end
        reset = 1'b0;
    endtask

    // Issues one request at the current negedge and follows it to done.
    // With hold set, req stays high with altered fields until done is seen.
    task automatic run_txn(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input int exp_done, input logic [DATA_W-1:0] exp_rd, input bit hold,
                           input string name);
        int cyc = 0;
        int low = 0;
        bit seen = 1'b0;
        bus.req      = 1'b1;
        bus.req_wr   = w;
        bus.req_addr = a;
        bus.req_data = d;
        @(negedge clk);
        if (hold) begin
            bus.req_addr = ~a;
            bus.req_data = ~d;
        end else begin
            bus.req = 1'b0;
        end
        vectors++;
        if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL %s/accept_busy: got %b expected 1", name, bus.busy); end
        while (!seen && cyc <= 40) begin
            vectors++;
            if (addr !== a) begin miscompares++; $display("FAIL %s/addr cyc %0d: got %h expected %h", name, cyc, addr, a); end
            if (wr === 1'b0) begin
                low++;
                vectors++;
                if (databus !== d) begin miscompares++; $display("FAIL %s/wdata cyc %0d: got %h expected %h", name, cyc, databus, d); end
            end
            if (!w && cyc == exp_done - 1) begin
                vectors++;
                if (databus !== mem[a]) begin miscompares++; $display("FAIL %s/rd_bus: got %h expected %h", name, databus, mem[a]); end
            end
            if (bus.done === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s/timeout: got no done in 40 cycles expected done at %0d", name, exp_done);
        end else begin
            if (cyc != exp_done) begin miscompares++; $display("FAIL %s/latency: got %0d expected %0d", name, cyc, exp_done); end
            vectors++;
            if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL %s/done_busy: got %b expected 0", name, bus.busy); end
            vectors++;
            if (bus.rd_data !== exp_rd) begin miscompares++; $display("FAIL %s/rd_data: got %h expected %h", name, bus.rd_data, exp_rd); end
        end
        vectors++;
        if (low != (w ? WR_WAIT : 0)) begin miscompares++; $display("FAIL %s/wr_low_cycles: got %0d expected %0d", name, low, w ? WR_WAIT : 0); end
        if (hold) bus.req = 1'b0;
    endtask

    task automatic test_write();
        run_txn(1'b1, 4'h2, 4'hA, WR_WAIT + 2, 4'h0, 1'b0, "write");
        vectors++;
        if (mem[2] !== 4'hA) begin miscompares++; $display("FAIL write/mem2: got %h expected a", mem[2]); end
    endtask

    task automatic test_read();
        run_txn(1'b0, 4'h2, 4'h5, RD_WAIT + 1, 4'hA, 1'b0, "read");
    endtask

    task automatic test_req_ignored();
        run_txn(1'b1, 4'h7, 4'h6, WR_WAIT + 2, 4'hA, 1'b1, "ignore");
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL ignore/second_done: got %b expected 0", bus.done); end
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL ignore/requeued: got busy %b expected 0", bus.busy); end
        vectors++;
        if (mem[7] !== 4'h6) begin miscompares++; $display("FAIL ignore/mem7: got %h expected 6", mem[7]); end
        vectors++;
        if (mem[8] !== 4'h7) begin miscompares++; $display("FAIL ignore/mem8: got %h expected 7", mem[8]); end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 4'h5, 4'h3, WR_WAIT + 2, 4'hA, 1'b0, "b2b_write");
        run_txn(1'b0, 4'h5, 4'hC, RD_WAIT + 1, 4'h3, 1'b0, "b2b_read");
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        bus.req      = 1'b1;
        bus.req_wr   = 1'b1;
        bus.req_addr = 4'h9;
        bus.req_data = 4'h4;
        @(negedge clk);
        bus.req = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (wr !== 1'b0) begin miscompares++; $display("FAIL abort/in_write: got wr %b expected 0", wr); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (wr !== 1'b1) begin miscompares++; $display("FAIL abort/wr: got %b expected 1", wr); end
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort/busy: got %b expected 0", bus.busy); end
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) dones++;
            @(negedge clk);
        end
        vectors++;
        if (dones != 0) begin miscompares++; $display("FAIL abort/done_pulses: got %0d expected 0", dones); end
        vectors++;
        if (mem[9] !== 4'h6) begin miscompares++; $display("FAIL abort/mem9: got %h expected 6", mem[9]); end
        run_txn(1'b0, 4'h9, 4'h1, RD_WAIT + 1, 4'h6, 1'b0, "after_abort");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'(15 - i);
        reset        = 1'b1;
        bus.req      = 1'b0;
        bus.req_wr   = 1'b0;
        bus.req_addr = '0;
        bus.req_data = '0;
        test_reset();
        test_write();
        test_read();
        test_req_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
